// File: rtl/parity_pkg.sv
// Shared parity constants and helpers for the parity strip/check datapath.
package parity_pkg;

    localparam int unsigned PAR_EVEN  = 0;
    localparam int unsigned PAR_ODD   = 1;
    localparam int unsigned PAR_MAX_W = 1024;

    function automatic int unsigned par_word_width(input int unsigned bits);
        return bits + 1;
    endfunction

    // Callers zero-extend their word to PAR_MAX_W; the extra zeros do not change the XOR.
    function automatic logic par_xor(input logic [PAR_MAX_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/parity_word_check.sv
// Combinational check of one parity-protected word: strips the MSB parity bit and flags a mismatch.
module parity_word_check
    import parity_pkg::*;
#(
    parameter int unsigned BITS_PER_WORD = 9
) (
    input  logic [BITS_PER_WORD:0]   word,
    input  logic                     odd_mode,
    output logic [BITS_PER_WORD-1:0] data,
    output logic                     err
);

    logic [PAR_MAX_W-1:0] w_ext;

    always_comb begin
        w_ext                  = '0;
        w_ext[BITS_PER_WORD:0] = word;
    end

    assign data = word[BITS_PER_WORD-1:0];
    assign err  = par_xor(w_ext) ^ odd_mode;

endmodule

// File: rtl/parity_strip_check.sv
// Parity stripper/checker with one registered valid/ready stage and error accounting.
// Optional error-beat counter is built only when PARITY_STRIP_CNT_EN is defined.
module parity_strip_check
    import parity_pkg::*;
#(
    parameter int unsigned WORDS         = 5,
    parameter int unsigned BITS_PER_WORD = 9,
    parameter int unsigned ODD_PARITY    = 0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                     clk,
    input  logic                                     sclr,
    input  logic [par_word_width(BITS_PER_WORD)*WORDS-1:0] din,
    input  logic                                     din_valid,
    output logic                                     din_ready,
    output logic [BITS_PER_WORD*WORDS-1:0]           dout,
    output logic                                     dout_valid,
    input  logic                                     dout_ready,
    output logic [WORDS-1:0]                         par_err,
    output logic                                     err_sticky,
    output logic [CNT_WIDTH-1:0]                     err_count,
    input  logic                                     err_clr
);

    localparam int unsigned WW = par_word_width(BITS_PER_WORD);

    logic                           w_odd_mode;
    logic                           w_accept;
    logic                           w_any_err;
    logic [BITS_PER_WORD*WORDS-1:0] w_data;
    logic [WORDS-1:0]               w_err;

    logic [BITS_PER_WORD*WORDS-1:0] r_dout;
    logic [WORDS-1:0]               r_par_err;
    logic                           r_dout_valid;
    logic                           r_err_sticky;

    assign w_odd_mode = (ODD_PARITY == PAR_ODD);

    for (genvar g = 0; g < WORDS; g++) begin : g_word
        parity_word_check #(
            .BITS_PER_WORD(BITS_PER_WORD)
        ) u_chk (
            .word    (din[g*WW +: WW]),
            .odd_mode(w_odd_mode),
            .data    (w_data[g*BITS_PER_WORD +: BITS_PER_WORD]),
            .err     (w_err[g])
        );
    end

    assign din_ready = !sclr && (!r_dout_valid || dout_ready);
    assign w_accept  = din_valid && din_ready;
    assign w_any_err = |w_err;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_dout       <= '0;
            r_par_err    <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_accept) begin
            r_dout       <= w_data;
            r_par_err    <= w_err;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    // A new errored beat beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (sclr) begin
            r_err_sticky <= 1'b0;
        end else if (w_accept && w_any_err) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

`ifdef PARITY_STRIP_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_err_count <= '0;
        end else if (w_accept && w_any_err) begin
            if (err_clr) begin
                r_err_count <= CNT_ONE;
            end else if (r_err_count != '1) begin
                r_err_count <= r_err_count + CNT_ONE;
            end
        end else if (err_clr) begin
            r_err_count <= '0;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign dout       = r_dout;
    assign par_err    = r_par_err;
    assign dout_valid = r_dout_valid;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_parity_strip_check.sv
// Directed bench for parity_strip_check: even instance (CNT_WIDTH=2) and odd instance.
module tb_parity_strip_check;

`ifdef PARITY_STRIP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    // even instance
    logic [19:0] e_din;
    logic        e_vld, e_rdy, e_clr, e_din_rdy, e_dvld, e_sticky;
    logic [17:0] e_dout;
    logic [1:0]  e_perr, e_cnt;

    // odd instance
    logic [19:0] o_din;
    logic        o_vld, o_rdy, o_clr, o_din_rdy, o_dvld, o_sticky;
    logic [17:0] o_dout;
    logic [1:0]  o_perr;
    logic [15:0] o_cnt;

    parity_strip_check #(
        .WORDS(2), .BITS_PER_WORD(9), .ODD_PARITY(0), .CNT_WIDTH(2)
    ) u_even (
        .clk(clk), .sclr(sclr), .din(e_din), .din_valid(e_vld), .din_ready(e_din_rdy),
        .dout(e_dout), .dout_valid(e_dvld), .dout_ready(e_rdy), .par_err(e_perr),
        .err_sticky(e_sticky), .err_count(e_cnt), .err_clr(e_clr)
    );

    parity_strip_check #(
        .WORDS(2), .BITS_PER_WORD(9), .ODD_PARITY(1), .CNT_WIDTH(16)
    ) u_odd (
        .clk(clk), .sclr(sclr), .din(o_din), .din_valid(o_vld), .din_ready(o_din_rdy),
        .dout(o_dout), .dout_valid(o_dvld), .dout_ready(o_rdy), .par_err(o_perr),
        .err_sticky(o_sticky), .err_count(o_cnt), .err_clr(o_clr)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned m_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned c);
        return CNT_EN ? c : 0;
    endfunction

    logic [19:0] BEAT_A, BEAT_B, BEAT_C, BEAT_D, BEAT_E1;
    logic [17:0] DATA_A, DATA_B, DATA_C, DATA_D;

    initial begin
        BEAT_A  = {1'b0, 9'h0FF, 1'b1, 9'h001};  DATA_A = {9'h0FF, 9'h001};
        BEAT_B  = {1'b0, 9'h0AA, 1'b1, 9'h1FF};  DATA_B = {9'h0AA, 9'h1FF};
        BEAT_C  = {1'b1, 9'h100, 1'b0, 9'h003};  DATA_C = {9'h100, 9'h003};
        BEAT_D  = {1'b0, 9'h003, 1'b0, 9'h005};  DATA_D = {9'h003, 9'h005};
        BEAT_E1 = {1'b0, 9'h0FF, 1'b0, 9'h001};  // word0 has a parity error

        sclr = 1'b1;
        e_din = '0; e_vld = 1'b0; e_rdy = 1'b1; e_clr = 1'b0;
        o_din = '0; o_vld = 1'b0; o_rdy = 1'b1; o_clr = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_dvld",   32'(e_dvld),    32'd0);
        chk("rst_dout",   32'(e_dout),    32'd0);
        chk("rst_perr",   32'(e_perr),    32'd0);
        chk("rst_sticky", 32'(e_sticky),  32'd0);
        chk("rst_cnt",    32'(e_cnt),     32'd0);
        chk("rst_rdy",    32'(e_din_rdy), 32'd0);
        sclr = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(e_din_rdy), 32'd1);

        // clean stream, one beat per cycle
        e_din = BEAT_A; e_vld = 1'b1;
        tick();
        chk("clean_a_dout", 32'(e_dout), 32'(DATA_A));
        chk("clean_a_dvld", 32'(e_dvld), 32'd1);
        chk("clean_a_perr", 32'(e_perr), 32'd0);
        chk("clean_a_rdy",  32'(e_din_rdy), 32'd1);
        e_din = BEAT_B;
        tick();
        chk("clean_b_dout", 32'(e_dout), 32'(DATA_B));
        chk("clean_b_perr", 32'(e_perr), 32'd0);
        e_din = BEAT_C;
        tick();
        chk("clean_c_dout", 32'(e_dout), 32'(DATA_C));
        chk("clean_c_perr", 32'(e_perr), 32'd0);
        e_vld = 1'b0;
        tick();
        chk("idle_dvld",   32'(e_dvld), 32'd0);
        chk("idle_hold",   32'(e_dout), 32'(DATA_C));
        chk("idle_sticky", 32'(e_sticky), 32'd0);

        // single-word error
        e_din = BEAT_E1; e_vld = 1'b1;
        tick();
        m_cnt = 1;
        chk("err1_perr",   32'(e_perr),   32'b01);
        chk("err1_dout",   32'(e_dout),   32'(DATA_A));
        chk("err1_sticky", 32'(e_sticky), 32'd1);
        chk("err1_cnt",    32'(e_cnt),    exp_cnt(m_cnt));

        // backpressure: pending beat holds, new beat waits
        e_din = BEAT_D; e_vld = 1'b1; e_rdy = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy",  32'(e_din_rdy), 32'd0);
            chk("bp_dout", 32'(e_dout),    32'(DATA_A));
            chk("bp_dvld", 32'(e_dvld),    32'd1);
            chk("bp_perr", 32'(e_perr),    32'b01);
            tick();
        end
        e_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(e_din_rdy), 32'd1);
        tick();
        chk("bp_d_dout", 32'(e_dout), 32'(DATA_D));
        chk("bp_d_perr", 32'(e_perr), 32'd0);
        chk("bp_d_dvld", 32'(e_dvld), 32'd1);
        chk("bp_d_cnt",  32'(e_cnt),  exp_cnt(m_cnt));
        e_vld = 1'b0;
        tick();
        chk("bp_no_dup", 32'(e_dvld), 32'd0);

        // saturation (CNT_WIDTH=2): four more errored beats, total five
        e_din = BEAT_E1; e_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_cnt < 3) m_cnt++;
            chk("sat_cnt", 32'(e_cnt), exp_cnt(m_cnt));
        end
        chk("sat_final", 32'(e_cnt), exp_cnt(3));

        // clear collides with an errored accept: the error wins
        e_clr = 1'b1;
        tick();
        m_cnt = 1;
        chk("clr_err_cnt",    32'(e_cnt),    exp_cnt(m_cnt));
        chk("clr_err_sticky", 32'(e_sticky), 32'd1);
        e_vld = 1'b0;
        tick();
        m_cnt = 0;
        chk("clr_cnt",    32'(e_cnt),    exp_cnt(m_cnt));
        chk("clr_sticky", 32'(e_sticky), 32'd0);
        chk("clr_dvld",   32'(e_dvld),   32'd0);
        e_clr = 1'b0;

        // odd parity instance
        o_din = {1'b1, 9'h0FF, 1'b0, 9'h001}; o_vld = 1'b1;
        tick();
        chk("odd_ok_perr", 32'(o_perr), 32'b00);
        chk("odd_ok_dout", 32'(o_dout), 32'(DATA_A));
        chk("odd_ok_stk",  32'(o_sticky), 32'd0);
        o_din = {1'b1, 9'h0FF, 1'b0, 9'h003};
        tick();
        chk("odd_w0_perr", 32'(o_perr), 32'b01);
        chk("odd_w0_dout", 32'(o_dout), 32'({9'h0FF, 9'h003}));
        o_din = {1'b1, 9'h0FE, 1'b0, 9'h001};
        tick();
        chk("odd_w1_perr", 32'(o_perr), 32'b10);
        chk("odd_stk",     32'(o_sticky), 32'd1);
        chk("odd_cnt",     32'(o_cnt), exp_cnt(2));
        o_vld = 1'b0;

        // reset mid-stream with a stalled errored beat
        e_din = BEAT_E1; e_vld = 1'b1; e_rdy = 1'b0;
        tick();
        m_cnt = 1;
        chk("pre_rst_dvld",   32'(e_dvld),   32'd1);
        chk("pre_rst_sticky", 32'(e_sticky), 32'd1);
        chk("pre_rst_cnt",    32'(e_cnt),    exp_cnt(m_cnt));
        sclr = 1'b1; e_rdy = 1'b1;
        #1;
        chk("sclr_rdy", 32'(e_din_rdy), 32'd0);
        tick();
        chk("sclr_dvld",   32'(e_dvld),   32'd0);
        chk("sclr_sticky", 32'(e_sticky), 32'd0);
        chk("sclr_cnt",    32'(e_cnt),    32'd0);
        chk("sclr_dout",   32'(e_dout),   32'd0);
        chk("sclr_perr",   32'(e_perr),   32'd0);
        chk("sclr_odd_stk", 32'(o_sticky), 32'd0);
        sclr = 1'b0; e_vld = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
